nibble_serial_alu_ctrl: RTL and testbench
=========================================

Name: nibble_serial_alu_ctrl

Overview:
- Sequencer that time-shares one `fulladder4` 4-bit ripple slice to add or subtract WIDTH-bit operands, one nibble per clock, least significant nibble first.
- Accepts a request through a valid/ready handshake and steps the slice through WIDTH/4 cycles, carrying between nibbles in a register.
- Presents the result, carry, signed overflow and zero flags through an output valid/ready handshake.
- Sits in the core's multi-cycle execute path as a low-area alternative to a full-width adder.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of 4 and at least 4; any other value is a configuration error (elaboration assertion).

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous active-high reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  controller can accept a request
- a_i  input  WIDTH  operand A, sampled on accept
- b_i  input  WIDTH  operand B, sampled on accept
- sub_i  input  1  0 = A+B, 1 = A-B; sampled on accept
- res_valid_o  output  1  result valid
- res_ready_i  input  1  consumer accepts result
- result_o  output  WIDTH  sum/difference
- carry_o  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow_o  output  1  signed two's-complement overflow
- zero_o  output  1  result_o == 0

Behaviour:
- Reset (async, rst_i=1):
  - State goes to IDLE; nibble counter and carry register go to 0.
  - Output values at reset: req_ready_o=1, res_valid_o=0, result_o=0, carry_o=0, overflow_o=0, zero_o=0.
  - Reset mid-operation discards the operation in progress; no result is produced.
- State machine:
  - IDLE:
    - req_ready_o=1.
    - Accept occurs when req_valid_i && req_ready_o on a rising edge.
    - On accept, latch A into the operand-A shift register.
    - Latch B, or ~B when sub_i=1, into the operand-B shift register.
    - Set the carry register to sub_i, clear the counter, go to RUN.
  - RUN:
    - req_ready_o=0.
    - Each cycle the slice adds the low nibble of the A and B shift registers plus the carry register.
    - The sum nibble shifts into the MSB end of the result register; A and B shift right by 4.
    - Slice carry_o is written to the carry register.
    - Counter increments. After the cycle with counter == WIDTH/4-1, go to DONE.
  - DONE:
    - res_valid_o=1.
    - result_o, carry_o, overflow_o and zero_o are held stable until the handshake completes.
    - When res_ready_i=1, go to IDLE.
    - req_ready_o=0 in DONE. No back-to-back accept in the same cycle as the result handoff.
- Latency: accept edge to res_valid_o high is WIDTH/4 + 1 rising edges (9 edges at WIDTH=32). Throughput is at most one operation per WIDTH/4 + 2 cycles.
- Flags:
  - carry_o is the final slice carry.
  - overflow_o = (A[MSB] == B_eff[MSB]) && (result_o[MSB] != A[MSB]), where B_eff is ~B for sub. A[MSB] and B_eff[MSB] are captured at accept.
  - zero_o is computed from the final result and registered with it.
- Flag outputs in states other than DONE: result_o and the flags hold the previous result; only res_valid_o qualifies them.
- Input rules:
  - Operand and sub_i inputs are ignored except on the accept edge.
  - req_valid_i asserted while req_ready_o=0 is ignored; the requester holds it.
- WIDTH=4: RUN lasts exactly one cycle.

Test Plan:
- Add, WIDTH=32: A=0x0000_0001, B=0x0000_0002, sub=0 -> after 9 edges res_valid_o=1, result=0x0000_0003, carry=0, ovf=0, zero=0.
- Carry chain across all nibbles: A=0xFFFF_FFFF, B=0x0000_0001, add -> result=0x0000_0000, carry=1, ovf=0, zero=1.
- Signed overflow and subtract:
  - A=0x7FFF_FFFF + B=0x0000_0001 -> result=0x8000_0000, ovf=1, carry=0.
  - 5-3 -> result=2, carry=1.
  - 3-5 -> result=0xFFFF_FFFE, carry=0, ovf=0.
- Output backpressure: hold res_ready_i=0 for 5 cycles after res_valid_o -> outputs stable, req_ready_o=0, new req_valid_i ignored. res_ready_i=1 -> IDLE next edge, req_ready_o=1.
- Reset mid-RUN: assert rst_i asynchronously at nibble 3 -> req_ready_o=1 and res_valid_o=0 immediately. A following request 0x10+0x20 returns 0x30 with correct latency.
- Change a_i/b_i/sub_i during RUN -> result reflects only the values latched on the accept edge. Repeat the add-test cases with WIDTH=4 (e.g. 0xF+0x1 -> 0x0, carry=1) and latency of 2 edges.

Source files
------------

// File: rtl/nibble_serial_alu_ctrl.sv
// Nibble-serial add/subtract sequencer built around one shared 4-bit ripple slice.
// Operands stream least significant nibble first; flags are registered with the result.

module fulladder4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
endmodule

module nibble_serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_alu_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q, b_q, acc_q, acc_d;
    logic [CW-1:0]     cnt_q;
    logic              carry_q;
    logic              a_msb_q, b_msb_q;
    logic              req_ready_q, res_valid_q;
    logic [WIDTH-1:0]  result_q;
    logic              carry_out_q, ovf_q, zero_q;
    logic [3:0]        sum;
    logic              slice_co;

    fulladder4 u_slice (
        .a_i (a_q[3:0]),
        .b_i (b_q[3:0]),
        .c_i (carry_q),
        .s_o (sum),
        .c_o (slice_co)
    );

    // Sum nibbles enter at the MSB end so the last one lands on top.
    assign acc_d = WIDTH'({sum, acc_q} >> 4);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        a_q         <= a_i;
                        b_q         <= sub_i ? ~b_i : b_i;
                        a_msb_q     <= a_i[WIDTH-1];
                        b_msb_q     <= sub_i ? ~b_i[WIDTH-1] : b_i[WIDTH-1];
                        carry_q     <= sub_i;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    acc_q   <= acc_d;
                    carry_q <= slice_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        result_q    <= acc_d;
                        carry_out_q <= slice_co;
                        ovf_q       <= (a_msb_q == b_msb_q) &&
                                       (acc_d[WIDTH-1] != a_msb_q);
                        zero_q      <= (acc_d == '0);
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign res_valid_o = res_valid_q;
    assign result_o    = result_q;
    assign carry_o     = carry_out_q;
    assign overflow_o  = ovf_q;
    assign zero_o      = zero_q;
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for the nibble-serial ALU sequencer at WIDTH=32 and WIDTH=4.
// Expected values are hand-computed constants.

module tb_nibble_serial_alu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rv32, rr32, sub32, qv32, qr32, c32, v32, z32;
    logic [31:0] a32, b32, r32;
    logic        rv4, rr4, sub4, qv4, qr4, c4, v4, z4;
    logic [3:0]  a4, b4, r4;

    int checks = 0;
    int errors = 0;

    nibble_serial_alu_ctrl #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(rv32), .req_ready_o(qr32),
        .a_i(a32), .b_i(b32), .sub_i(sub32),
        .res_valid_o(qv32), .res_ready_i(rr32),
        .result_o(r32), .carry_o(c32), .overflow_o(v32), .zero_o(z32)
    );

    nibble_serial_alu_ctrl #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(rv4), .req_ready_o(qr4),
        .a_i(a4), .b_i(b4), .sub_i(sub4),
        .res_valid_o(qv4), .res_ready_i(rr4),
        .result_o(r4), .carry_o(c4), .overflow_o(v4), .zero_o(z4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs during RUN, check latency and outputs.
    task automatic op(input bit w4, input string tag,
                      input logic [31:0] a, input logic [31:0] b, input bit s,
                      input logic [31:0] er, input bit ec, input bit ev, input bit ez,
                      input int hold);
        int edges;
        logic [31:0] res;
        logic vld;
        if (w4) begin
            chk({tag, "_rdy"}, {31'b0, qr4}, 32'd1);
            a4 = a[3:0]; b4 = b[3:0]; sub4 = s; rv4 = 1'b1;
        end else begin
            chk({tag, "_rdy"}, {31'b0, qr32}, 32'd1);
            a32 = a; b32 = b; sub32 = s; rv32 = 1'b1;
        end
        @(posedge clk); #1;
        rv4 = 1'b0; rv32 = 1'b0;
        a32 = $urandom; b32 = $urandom; sub32 = ~s;
        a4 = 4'($urandom); b4 = 4'($urandom); sub4 = ~s;
        edges = 1;
        vld = w4 ? qv4 : qv32;
        while (!vld && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            vld = w4 ? qv4 : qv32;
        end
        chk({tag, "_lat"}, edges, w4 ? 32'd2 : 32'd9);
        for (int i = 0; i <= hold; i++) begin
            res = w4 ? {28'b0, r4} : r32;
            chk({tag, "_res"}, res, er);
            chk({tag, "_flags"},
                w4 ? {29'b0, c4, v4, z4} : {29'b0, c32, v32, z32},
                {29'b0, ec, ev, ez});
            if (i < hold) begin
                chk({tag, "_bp_rdy"}, {31'b0, qr32}, 32'd0);
                chk({tag, "_bp_vld"}, {31'b0, qv32}, 32'd1);
                rv32 = 1'b1; a32 = 32'h1234_5678;
                @(posedge clk); #1;
            end
        end
        rv32 = 1'b0;
        if (w4) rr4 = 1'b1; else rr32 = 1'b1;
        @(posedge clk); #1;
        rr4 = 1'b0; rr32 = 1'b0;
        chk({tag, "_idle_rdy"}, w4 ? {31'b0, qr4} : {31'b0, qr32}, 32'd1);
        chk({tag, "_idle_vld"}, w4 ? {31'b0, qv4} : {31'b0, qv32}, 32'd0);
    endtask

    initial begin
        rv32 = 0; rr32 = 0; sub32 = 0; a32 = 0; b32 = 0;
        rv4 = 0; rr4 = 0; sub4 = 0; a4 = 0; b4 = 0;
        #12;
        chk("rst_rdy", {31'b0, qr32}, 32'd1);
        chk("rst_vld", {31'b0, qv32}, 32'd0);
        chk("rst_res", r32, 32'd0);
        chk("rst_flags", {29'b0, c32, v32, z32}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        op(0, "add1_2", 32'h1, 32'h2, 0, 32'h3, 0, 0, 0, 0);
        op(0, "carry", 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1, 0, 1, 0);
        op(0, "ovf", 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0, 1, 0, 0);
        op(0, "sub5_3", 32'd5, 32'd3, 1, 32'd2, 1, 0, 0, 0);
        op(0, "sub3_5", 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        op(0, "bp", 32'h1, 32'h2, 0, 32'h3, 0, 0, 0, 5);

        // Reset during RUN at nibble 3.
        a32 = 32'hAAAA_AAAA; b32 = 32'h5555_5555; sub32 = 0; rv32 = 1'b1;
        @(posedge clk); #1; rv32 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rdy", {31'b0, qr32}, 32'd1);
        chk("mid_rst_vld", {31'b0, qv32}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        op(0, "post_rst", 32'h10, 32'h20, 0, 32'h30, 0, 0, 0, 0);

        op(1, "w4_carry", 32'hF, 32'h1, 0, 32'h0, 1, 0, 1, 0);
        op(1, "w4_add", 32'h1, 32'h2, 0, 32'h3, 0, 0, 0, 0);
        op(1, "w4_ovf", 32'h7, 32'h1, 0, 32'h8, 0, 1, 0, 0);
        op(1, "w4_sub", 32'h5, 32'h3, 1, 32'h2, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
